// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared frame limits and state encodings for the SPI transaction engine
package spi_cmd_pkg;

    localparam int MAX_BYTES    = 260;
    localparam int GUARD_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_GUARD
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SEND,
        PH_RECV
    } io_phase_e;

endpackage

// File: rtl/spi_cmd_io.sv
// rtl/spi_cmd_io.sv - per-lane DQ output enable/value mux and tristate drivers
module spi_cmd_io
    import spi_cmd_pkg::*;
(
    input  logic       en_i,
    input  logic       quad_i,
    input  logic [1:0] phase_i,
    input  logic [3:0] nibble_i,
    output logic [3:0] dq_rd_o,
    inout  wire  [3:0] dq_io
);

    logic [3:0] oe;
    logic [3:0] val;

    // In x1, DQ2/DQ3 act as W#/HOLD# and are held inactive whenever enabled
    always_comb begin
        oe  = 4'b0000;
        val = 4'b0000;
        if (en_i) begin
            case (phase_i)
                PH_IDLE: begin
                    oe  = 4'b1100;
                    val = 4'b1100;
                end
                PH_SEND: begin
                    if (quad_i) begin
                        oe  = 4'b1111;
                        val = nibble_i;
                    end else begin
                        oe  = 4'b1101;
                        val = {2'b11, 1'b0, nibble_i[3]};
                    end
                end
                PH_RECV: begin
                    if (!quad_i) begin
                        oe  = 4'b1100;
                        val = 4'b1100;
                    end
                end
                default: begin
                    oe  = 4'b0000;
                    val = 4'b0000;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign dq_io[i] = oe[i] ? val[i] : 1'bz;
    end

    assign dq_rd_o = dq_io;

endmodule

// File: rtl/spi_cmd.sv
// rtl/spi_cmd.sv - x1/x4 SPI frame engine: send N bytes, optionally read one byte
// Optional simulation checks are enabled by defining SPI_CMD_ASSERT_EN.
module spi_cmd
    import spi_cmd_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic                   quad,
    input  logic [8:0]             data_in_count,
    input  logic                   data_out_count,
    input  logic [MAX_BYTES*8-1:0] data_in,
    output logic [7:0]             data_out,
    output logic                   busy,
    inout  wire  [3:0]             DQio,
    output logic                   S,
    output logic                   C
);

    localparam int SW = MAX_BYTES * 8;

    state_e        state_q;
    logic          busy_q, s_q, c_q, quad_q, rd_q;
    logic [7:0]    data_out_q, rx_q, rx_d;
    logic [SW-1:0] shreg_q, load_d;
    logic [11:0]   clks_q, send_clks_d;
    logic [3:0]    guard_q;
    logic [8:0]    n_send;
    logic [3:0]    dq_rd;
    io_phase_e     phase;

    // Payload is left-aligned at latch time so the next bit/nibble is always the MSBs
    always_comb begin
        n_send      = (data_in_count > 9'(MAX_BYTES)) ? 9'(MAX_BYTES) : data_in_count;
        load_d      = data_in << (8 * (MAX_BYTES - int'(n_send)));
        send_clks_d = quad ? {2'b00, n_send, 1'b0} : {n_send, 3'b000};
        rx_d        = quad_q ? {rx_q[3:0], dq_rd} : {rx_q[6:0], dq_rd[1]};
        case (state_q)
            ST_SEND: phase = PH_SEND;
            ST_RECV: phase = PH_RECV;
            default: phase = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            s_q        <= 1'b1;
            c_q        <= 1'b0;
            quad_q     <= 1'b0;
            rd_q       <= 1'b0;
            data_out_q <= 8'h00;
            rx_q       <= 8'h00;
            shreg_q    <= '0;
            clks_q     <= '0;
            guard_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        busy_q  <= 1'b1;
                        quad_q  <= quad;
                        rd_q    <= data_out_count;
                        shreg_q <= load_d;
                        if (n_send != 9'd0) begin
                            state_q <= ST_SEND;
                            s_q     <= 1'b0;
                            clks_q  <= send_clks_d;
                        end else if (data_out_count) begin
                            state_q <= ST_RECV;
                            s_q     <= 1'b0;
                            clks_q  <= quad ? 12'd2 : 12'd8;
                        end else begin
                            state_q <= ST_GUARD;
                            guard_q <= 4'(GUARD_CYCLES - 1);
                        end
                    end
                end
                ST_SEND: begin
                    c_q <= ~c_q;
                    if (c_q) begin
                        shreg_q <= quad_q ? (shreg_q << 4) : (shreg_q << 1);
                        if (clks_q == 12'd1) begin
                            if (rd_q) begin
                                state_q <= ST_RECV;
                                clks_q  <= quad_q ? 12'd2 : 12'd8;
                            end else begin
                                state_q <= ST_GUARD;
                                s_q     <= 1'b1;
                                guard_q <= 4'(GUARD_CYCLES - 1);
                            end
                        end else begin
                            clks_q <= clks_q - 12'd1;
                        end
                    end
                end
                ST_RECV: begin
                    c_q <= ~c_q;
                    if (c_q) begin
                        rx_q <= rx_d;
                        if (clks_q == 12'd1) begin
                            data_out_q <= rx_d;
                            state_q    <= ST_GUARD;
                            s_q        <= 1'b1;
                            guard_q    <= 4'(GUARD_CYCLES - 1);
                        end else begin
                            clks_q <= clks_q - 12'd1;
                        end
                    end
                end
                default: begin
                    if (guard_q == 4'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        guard_q <= guard_q - 4'd1;
                    end
                end
            endcase
        end
    end

    spi_cmd_io u_io (
        .en_i    (~reset),
        .quad_i  (quad_q),
        .phase_i (phase),
        .nibble_i(shreg_q[SW-1 -: 4]),
        .dq_rd_o (dq_rd),
        .dq_io   (DQio)
    );

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign S        = s_q;
    assign C        = c_q;

`ifdef SPI_CMD_ASSERT_EN
    int assert_errors = 0;
    always @(posedge clk) begin
        if (!reset) begin
            if (trigger && busy_q) begin
                $display("spi_cmd: trigger while busy at %0t", $time);
                assert_errors = assert_errors + 1;
            end
            if (trigger && !busy_q && (data_in_count > 9'(MAX_BYTES))) begin
                $display("spi_cmd: data_in_count %0d above limit at %0t", data_in_count, $time);
                assert_errors = assert_errors + 1;
            end
            if ((state_q == ST_RECV) && c_q && (quad_q ? $isunknown(dq_rd) : $isunknown(dq_rd[1]))) begin
                $display("spi_cmd: unknown DQ at read sample at %0t", $time);
                assert_errors = assert_errors + 1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmd.sv
// tb/tb_spi_cmd.sv - scoreboard bench for spi_cmd with a small N25Q-style read model
module tb_spi_cmd;
    import spi_cmd_pkg::*;

    localparam int SW = MAX_BYTES * 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          trigger = 1'b0;
    logic          quad = 1'b0;
    logic          data_out_count = 1'b0;
    logic [8:0]    data_in_count = 9'd0;
    logic [SW-1:0] data_in = '0;
    logic [7:0]    data_out;
    logic          busy, S, C;
    wire  [3:0]    DQio;
    logic [3:0]    flash_oe = 4'h0;
    logic [3:0]    flash_val = 4'h0;

    for (genvar i = 0; i < 4; i++) begin : g_flash
        assign DQio[i] = flash_oe[i] ? flash_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    spi_cmd dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .quad          (quad),
        .data_in_count (data_in_count),
        .data_out_count(data_out_count),
        .data_in       (data_in),
        .data_out      (data_out),
        .busy          (busy),
        .DQio          (DQio),
        .S             (S),
        .C             (C)
    );

    typedef struct {
        logic [3:0] val;
        logic [3:0] vmask;
        logic [3:0] zmask;
    } dq_exp_t;

    typedef struct {
        int         blen;
        int         slen;
        logic [7:0] dout;
    } frame_exp_t;

    dq_exp_t    q_dq[$];
    frame_exp_t q_fr[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash model: presents read data from the C falling edge that precedes each read clock
    logic       m_rd = 1'b0;
    logic       m_quad = 1'b0;
    int         m_ksend = 0;
    logic [7:0] m_byte = 8'h00;
    int         falls = 0;
    logic       fc_prev = 1'b0;

    always @(negedge clk) begin
        int j;
        if (reset || S) begin
            falls    = 0;
            fc_prev  = 1'b0;
            flash_oe = 4'h0;
        end else begin
            if (fc_prev && !C) falls++;
            fc_prev = C;
            j = falls - m_ksend;
            if (m_rd && j >= 0 && j < (m_quad ? 2 : 8)) begin
                if (m_quad) begin
                    flash_oe  = 4'hf;
                    flash_val = (j == 0) ? m_byte[7:4] : m_byte[3:0];
                end else begin
                    flash_oe  = 4'b0010;
                    flash_val = {2'b00, m_byte[7-j], 1'b0};
                end
            end else begin
                flash_oe = 4'h0;
            end
        end
    end

    // Monitor: one DQ entry per C rising edge, one frame entry per busy fall
    int   bcnt = 0;
    int   scnt = 0;
    logic mc_prev = 1'b0;
    logic mb_prev = 1'b0;

    always @(negedge clk) begin
        dq_exp_t    e;
        frame_exp_t f;
        if (reset) begin
            bcnt = 0; scnt = 0; mc_prev = 1'b0; mb_prev = 1'b0;
        end else begin
            if (C && !mc_prev) begin
                if (q_dq.size() == 0) begin
                    check("unexpected_c_edge", 32'd1, 32'd0);
                end else begin
                    e = q_dq.pop_front();
                    check("dq_lanes", {24'd0, DQio & e.vmask, dut.u_io.oe & e.zmask},
                          {24'd0, e.val & e.vmask, 4'h0});
                end
            end
            mc_prev = C;
            if (busy) begin
                bcnt++;
                if (!S) scnt++;
            end else if (mb_prev) begin
                if (q_fr.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    f = q_fr.pop_front();
                    check("busy_len", 32'(bcnt), 32'(f.blen));
                    check("s_low_len", 32'(scnt), 32'(f.slen));
                    check("data_out", {24'd0, data_out}, {24'd0, f.dout});
                end
                bcnt = 0; scnt = 0;
            end
            mb_prev = busy;
        end
    end

    task automatic run_frame(input logic q, input int n, input logic nout, input logic [7:0] rbyte,
                             input int blen, input int slen, input logic [7:0] dout,
                             input bit glitch, input int abort_at);
        int         neff;
        int         nrd;
        dq_exp_t    e;
        frame_exp_t f;
        logic       done;
        neff = (n > MAX_BYTES) ? MAX_BYTES : n;
        nrd  = nout ? (q ? 2 : 8) : 0;
        for (int b = 0; b < neff * (q ? 2 : 8); b++) begin
            if (q) begin
                e.val = data_in[8*neff-1-4*b -: 4]; e.vmask = 4'hf; e.zmask = 4'h0;
            end else begin
                e.val = {2'b11, 1'b0, data_in[8*neff-1-b]}; e.vmask = 4'b1101; e.zmask = 4'b0010;
            end
            q_dq.push_back(e);
        end
        for (int r = 0; r < nrd; r++) begin
            e.val   = q ? 4'h0 : 4'b1100;
            e.vmask = q ? 4'h0 : 4'b1100;
            e.zmask = q ? 4'hf : 4'b0010;
            q_dq.push_back(e);
        end
        f.blen = blen; f.slen = slen; f.dout = dout;
        q_fr.push_back(f);
        m_rd = nout; m_quad = q; m_ksend = neff * (q ? 2 : 8); m_byte = rbyte;
        quad = q; data_in_count = 9'(n); data_out_count = nout; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        done = 1'b0;
        for (int i = 0; i < blen + 20 && !done; i++) begin
            if (glitch && i == 100) begin
                trigger = 1'b1; quad = ~q; data_in_count = 9'd3; data_out_count = ~nout; data_in = ~data_in;
            end
            if (glitch && i == 101) trigger = 1'b0;
            if (i == abort_at) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                check("abort_S", {31'd0, S}, 32'd1);
                check("abort_C", {31'd0, C}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_oe", {28'd0, dut.u_io.oe}, 32'd0);
                check("abort_data_out", {24'd0, data_out}, 32'd0);
                @(negedge clk);
                q_dq.delete();
                q_fr.delete();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (!busy) done = 1'b1;
            else @(negedge clk);
        end
        check("frame_done", {31'd0, done}, 32'd1);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < MAX_BYTES; i++) data_in[8*i +: 8] = 8'(i * 37 + 11);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_S", {31'd0, S}, 32'd1);
        check("reset_C", {31'd0, C}, 32'd0);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_oe", {28'd0, dut.u_io.oe}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_dq32", {30'd0, DQio[3:2]}, 32'd3);
        check("idle_oe", {28'd0, dut.u_io.oe}, 32'hc);

        data_in = '0; data_in[7:0] = 8'h06;
        run_frame(1'b0, 1, 1'b0, 8'h00, 18, 16, 8'h00, 1'b0, -1);
        data_in[7:0] = 8'h05;
        run_frame(1'b0, 1, 1'b1, 8'h80, 34, 32, 8'h80, 1'b0, -1);
        data_in = '0; data_in[31:0] = 32'hD801_2345;
        run_frame(1'b1, 4, 1'b0, 8'h00, 18, 16, 8'h80, 1'b0, -1);
        data_in = '0; data_in[7:0] = 8'hAF;
        run_frame(1'b1, 1, 1'b1, 8'h20, 10, 8, 8'h20, 1'b0, -1);
        run_frame(1'b0, 0, 1'b0, 8'h00, 2, 0, 8'h20, 1'b0, -1);

        fill_pattern();
        run_frame(1'b1, 300, 1'b0, 8'h00, 1042, 1040, 8'h20, 1'b0, -1);
        run_frame(1'b0, 260, 1'b0, 8'h00, 4162, 4160, 8'h20, 1'b1, -1);
        fill_pattern();
        run_frame(1'b0, 260, 1'b0, 8'h00, 4162, 4160, 8'h20, 1'b0, 150);

        data_in = '0; data_in[7:0] = 8'h06;
        run_frame(1'b0, 1, 1'b0, 8'h00, 18, 16, 8'h00, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("dq_queue_empty", 32'(q_dq.size()), 32'd0);
        check("frame_queue_empty", 32'(q_fr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
